// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - 16-bit serial frame transmitter to a 12-bit DAC; DAC_SAT_EN selects clamped mapping
module dac_spi_tx #(
  parameter int         cant_bits = 13,
  parameter int         DIV       = 4,
  parameter logic [1:0] PD_MODE   = 2'b00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [cant_bits-1:0] dato_in,
  output logic                 cs,
  output logic                 sclk,
  output logic                 sdata,
  output logic                 busy,
  output logic                 done
);

  // One counter serves both the sclk half-period and the inter-frame gap.
  localparam int            CW        = $clog2(2 * DIV) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(2 * DIV - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   shift_q, shift_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic          sclk_q, sclk_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [11:0]   code_in;
  logic [15:0]   frame_in;

`ifdef DAC_SAT_EN
  // Clamp the signed sample into the unsigned 0..4095 DAC range.
  assign code_in = dato_in[cant_bits-1] ? 12'h000 :
                   (dato_in[cant_bits-2:0] > (cant_bits-1)'(4095)) ? 12'hFFF :
                   dato_in[11:0];
`else
  // Offset binary: flip the sign bit and keep the 11 bits below it.
  logic unused_lsbs;
  assign code_in     = {~dato_in[cant_bits-1], dato_in[cant_bits-2 -: 11]};
  assign unused_lsbs = ^dato_in[cant_bits-13:0];
`endif

  assign frame_in = {2'b00, PD_MODE, code_in};

  // Outputs decode straight from registered state.
  assign cs    = (state_q != ST_SHIFT);
  assign sdata = (state_q == ST_SHIFT) & shift_q[15];
  assign busy  = (state_q != ST_IDLE);
  assign sclk  = sclk_q;
  assign done  = done_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      sclk_q   <= 1'b1;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      sclk_q   <= sclk_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
    end
  end

  // Next-state logic: frame sequencing, sclk generation and pending capture.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    sclk_d   = sclk_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    bit_d    = bit_q;

    // Any start while a frame or gap is running parks the newest sample.
    if (start && (state_q != ST_IDLE)) begin
      pend_d   = frame_in;
      pend_v_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b1;
        if (start) begin
          shift_d = frame_in;
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == 4'd15) begin
            sclk_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_GAP;
          end else begin
            sclk_d  = 1'b1;
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d    = '0;
          bit_d    = '0;
          pend_v_d = 1'b0;
          if (start) begin
            shift_d = frame_in;
            state_d = ST_SHIFT;
          end else if (pend_v_q) begin
            shift_d = pend_q;
            state_d = ST_SHIFT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb/tb_dac_spi_tx.sv - directed self-checking bench for dac_spi_tx with DIV=2
module tb_dac_spi_tx;

`ifdef DAC_SAT_EN
  localparam logic [15:0] E_M1   = 16'h0000;
  localparam logic [15:0] E_ZERO = 16'h0000;
  localparam logic [15:0] E_FFF  = 16'h0FFF;
  localparam logic [15:0] E_A    = 16'h0100;
  localparam logic [15:0] E_C    = 16'h0300;
  localparam logic [15:0] E_PD   = 16'h3000;
`else
  localparam logic [15:0] E_M1   = 16'h07FF;
  localparam logic [15:0] E_ZERO = 16'h0800;
  localparam logic [15:0] E_FFF  = 16'h0FFF;
  localparam logic [15:0] E_A    = 16'h0880;
  localparam logic [15:0] E_C    = 16'h0980;
  localparam logic [15:0] E_PD   = 16'h3800;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] dato_in;
  logic        cs, sclk, sdata, busy, done;
  logic        cs2, sclk2, sdata2, busy2, done2;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;

  dac_spi_tx #(.cant_bits(13), .DIV(2), .PD_MODE(2'b00)) dut (
    .clk(clk), .rst(rst), .start(start), .dato_in(dato_in),
    .cs(cs), .sclk(sclk), .sdata(sdata), .busy(busy), .done(done)
  );

  dac_spi_tx #(.cant_bits(13), .DIV(2), .PD_MODE(2'b11)) dut_pd (
    .clk(clk), .rst(rst), .start(start), .dato_in(dato_in),
    .cs(cs2), .sclk(sclk2), .sdata(sdata2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: shifts sdata in on every sclk fall while cs is low, logs each frame on cs rise.
  logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_sd = 1'b0;
  logic [15:0] frm = '0;
  int          low_cnt = 0, falls = 0, last_fall = 0, bad_sp = 0, bad_sd = 0, nf = 0, ndone = 0;
  logic [15:0] frm_log [0:15];
  int          len_log [0:15];
  int          falls_log [0:15];
  int          sp_log [0:15];
  int          sd_log [0:15];
  int          st_log [0:15];
  int          end_log [0:15];
  logic        done_log [0:15];
  logic        prev_cs2 = 1'b1, prev_sclk2 = 1'b1;
  logic [15:0] frm2 = '0, frm2_last = '0;

  always @(negedge clk) begin
    prev_cs   <= cs;
    prev_sclk <= sclk;
    prev_sd   <= sdata;
    if (done === 1'b1) ndone <= ndone + 1;
    if (cs === 1'b0) begin
      if (prev_cs) begin
        frm     <= '0;
        low_cnt <= 1;
        falls   <= 0;
        bad_sp  <= 0;
        bad_sd  <= 0;
        st_log[nf[3:0]] <= cyc;
      end else begin
        low_cnt <= low_cnt + 1;
        if (prev_sclk && !sclk) begin
          frm       <= {frm[14:0], sdata};
          falls     <= falls + 1;
          last_fall <= cyc;
          if (falls > 0 && (cyc - last_fall) != 4) bad_sp <= bad_sp + 1;
        end
        if (sdata !== prev_sd && !(sclk && !prev_sclk)) bad_sd <= bad_sd + 1;
      end
    end else if (!prev_cs) begin
      frm_log[nf[3:0]]   <= frm;
      len_log[nf[3:0]]   <= low_cnt;
      falls_log[nf[3:0]] <= falls;
      sp_log[nf[3:0]]    <= bad_sp;
      sd_log[nf[3:0]]    <= bad_sd;
      end_log[nf[3:0]]   <= cyc;
      done_log[nf[3:0]]  <= done;
      nf <= nf + 1;
    end

    prev_cs2   <= cs2;
    prev_sclk2 <= sclk2;
    if (cs2 === 1'b0) begin
      if (prev_cs2) frm2 <= '0;
      else if (prev_sclk2 && !sclk2) frm2 <= {frm2[14:0], sdata2};
    end else if (!prev_cs2) begin
      frm2_last <= frm2;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [12:0] d);
    @(negedge clk);
    dato_in = d;
    start   = 1'b1;
    t0      = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  int t_done, t_idle, n0, nd0, i1;

  initial begin
    rst = 1'b1; start = 1'b0; dato_in = '0;

    // Reset held for three cycles while start toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_cs",    {31'd0, cs},    32'd1);
      chk("rst_sclk",  {31'd0, sclk},  32'd1);
      chk("rst_sdata", {31'd0, sdata}, 32'd0);
      chk("rst_busy",  {31'd0, busy},  32'd0);
      chk("rst_done",  {31'd0, done},  32'd0);
      chk("rst_busy_pd", {31'd0, busy2}, 32'd0);
      start   = ~start;
      dato_in = 13'h0AAA;
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("idle_cs", {31'd0, cs}, 32'd1);

    // Timing with -1.
    send(13'h1FFF);
    chk("cs_low_c1", {31'd0, cs}, 32'd0);
    chk("busy_c1",   {31'd0, busy}, 32'd1);
    t_done = -1; t_idle = -1;
    for (int k = 0; k < 200 && t_idle < 0; k++) begin
      @(negedge clk);
      if (done === 1'b1 && t_done < 0) t_done = cyc - t0;
      if (busy === 1'b0) t_idle = cyc - t0;
    end
    chk("done_cycle", t_done, 32'd65);
    chk("busy_low_cycle", t_idle, 32'd69);
    i1 = nf - 1;
    chk("frame_m1",  {16'd0, frm_log[i1]}, {16'd0, E_M1});
    chk("cs_low_len", len_log[i1], 32'd64);
    chk("sclk_falls", falls_log[i1], 32'd16);
    chk("fall_spacing", sp_log[i1], 32'd0);
    chk("sdata_stable", sd_log[i1], 32'd0);
    chk("done_at_end", {31'd0, done_log[i1]}, 32'd1);

    // Mapping: zero and full positive; PD_MODE instance on zero.
    send(13'h0000);
    wait_idle("idle_zero");
    chk("frame_zero", {16'd0, frm_log[nf-1]}, {16'd0, E_ZERO});
    chk("frame_pd11", {16'd0, frm2_last}, {16'd0, E_PD});
    send(13'h0FFF);
    wait_idle("idle_fff");
    chk("frame_fff", {16'd0, frm_log[nf-1]}, {16'd0, E_FFF});

    // Pending buffer: A, B at 10, C at 20 -> A then C.
    n0 = nf;
    send(13'h0100);
    while (cyc - t0 < 10) @(negedge clk);
    start = 1'b1; dato_in = 13'h0200;
    @(negedge clk);
    start = 1'b0;
    while (cyc - t0 < 20) @(negedge clk);
    start = 1'b1; dato_in = 13'h0300;
    @(negedge clk);
    start = 1'b0;
    wait_idle("idle_pend");
    repeat (10) @(negedge clk);
    chk("pend_nframes", nf - n0, 32'd2);
    chk("pend_frame_a", {16'd0, frm_log[n0]}, {16'd0, E_A});
    chk("pend_frame_c", {16'd0, frm_log[n0+1]}, {16'd0, E_C});
    chk("pend_gap", st_log[n0+1] - end_log[n0], 32'd4);
    chk("pend_len_c", len_log[n0+1], 32'd64);

    // Reset after the 7th sclk fall.
    send(13'h0FFF);
    while (cyc - t0 < 27) @(negedge clk);
    rst = 1'b1;
    nd0 = ndone;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_cs",    {31'd0, cs},    32'd1);
    chk("mid_rst_sclk",  {31'd0, sclk},  32'd1);
    chk("mid_rst_sdata", {31'd0, sdata}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy},  32'd0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", ndone - nd0, 32'd0);
    chk("mid_rst_falls", falls_log[nf-1], 32'd7);
    send(13'h0FFF);
    wait_idle("idle_after_rst");
    chk("after_rst_frame", {16'd0, frm_log[nf-1]}, {16'd0, E_FFF});
    chk("after_rst_len", len_log[nf-1], 32'd64);
    chk("after_rst_done", {31'd0, done_log[nf-1]}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
